// File: rtl/ht_res_collector_pkg.sv
// Shared hash-table result types: command/result codes and the buffered entry layout.
package hash_table;

    localparam int KEY_WIDTH   = 32;
    localparam int VALUE_WIDTH = 16;

    typedef enum logic [1:0] {
        INSERT     = 2'd0,
        DELETE     = 2'd1,
        SEARCH     = 2'd2,
        DELETE_ALL = 2'd3
    } ht_cmd_t;

    typedef enum logic [2:0] {
        NO_OP                            = 3'd0,
        INSERT_SUCCESS                   = 3'd1,
        INSERT_SUCCESS_SAME_KEY          = 3'd2,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd3,
        DELETE_SUCCESS                   = 3'd4,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd5,
        SEARCH_FOUND                     = 3'd6,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd7
    } ht_rescode_t;

    typedef struct packed {
        ht_cmd_t                cmd;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_rescode_t            rescode;
    } ht_res_entry_t;

endpackage

// File: rtl/ht_res_if.sv
// Valid/ready result stream from hash_table_top towards its consumers.
interface ht_res_if;
    import hash_table::*;

    logic                   valid;
    logic                   ready;
    ht_cmd_t                cmd;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_rescode_t            rescode;

    modport src (output valid, cmd, key, value, rescode, input ready);
    modport snk (input valid, cmd, key, value, rescode, output ready);
endinterface

// File: rtl/ht_res_collector_fifo.sv
// Synchronous first-word-fall-through FIFO of result entries; head shows mem[rd_ptr].
// Push on full and pop on empty are ignored; full/empty come from the occupancy counter.
module ht_res_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  ht_res_entry_t push_dat_i,
    input  logic          pop_i,
    output ht_res_entry_t pop_dat_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ht_res_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ht_res_collector.sv
// Buffers hash-table results in a FWFT FIFO and keeps saturating result statistics.
// Stream ready is either NOT full (backpressure) or always high with overflow dropped and counted.
module ht_res_collector
    import hash_table::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 32,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ht_res_if.snk                  ht_res_in,
    input  logic                   clear_i,
    input  logic                   rd_req_i,
    output logic                   rd_valid_o,
    output ht_cmd_t                rd_cmd_o,
    output logic [KEY_WIDTH-1:0]   rd_key_o,
    output logic [VALUE_WIDTH-1:0] rd_value_o,
    output ht_rescode_t            rd_rescode_o,
    output logic [CNT_WIDTH-1:0]   total_cnt_o,
    output logic [CNT_WIDTH-1:0]   found_cnt_o,
    output logic [CNT_WIDTH-1:0]   miss_cnt_o,
    output logic [CNT_WIDTH-1:0]   drop_cnt_o
);
    logic          rdy_en_q;
    logic          fifo_full, fifo_empty;
    logic          rdy, accept, push, pop, drop;
    logic          is_found, is_miss;
    ht_res_entry_t wr_entry, head_entry;

    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] found_q, found_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        if (en && (v != '1)) begin
            return v + CNT_WIDTH'(1);
        end
        return v;
    endfunction

    // rdy_en_q holds ready low through reset and for the first edge after release.
    assign rdy             = DROP_ON_FULL ? rdy_en_q : (rdy_en_q & ~fifo_full);
    assign ht_res_in.ready = rdy;

    assign accept   = ht_res_in.valid & rdy;
    assign push     = accept & ~fifo_full;
    assign drop     = accept & fifo_full;
    assign pop      = rd_req_i & ~fifo_empty;
    assign is_found = (ht_res_in.rescode == SEARCH_FOUND);
    assign is_miss  = (ht_res_in.rescode == SEARCH_NOT_SUCCESS_NO_ENTRY);

    assign wr_entry = '{cmd:     ht_res_in.cmd,
                        key:     ht_res_in.key,
                        value:   ht_res_in.value,
                        rescode: ht_res_in.rescode};

    ht_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (wr_entry),
        .pop_i      (pop),
        .pop_dat_o  (head_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign rd_valid_o   = ~fifo_empty;
    assign rd_cmd_o     = head_entry.cmd;
    assign rd_key_o     = head_entry.key;
    assign rd_value_o   = head_entry.value;
    assign rd_rescode_o = head_entry.rescode;

    always_comb begin
        total_d = total_q;
        found_d = found_q;
        miss_d  = miss_q;
        drop_d  = drop_q;
        if (clear_i) begin
            total_d = '0;
            found_d = '0;
            miss_d  = '0;
            drop_d  = '0;
        end else begin
            total_d = sat_inc(total_q, accept);
            found_d = sat_inc(found_q, accept & is_found);
            miss_d  = sat_inc(miss_q, accept & is_miss);
            drop_d  = sat_inc(drop_q, drop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_en_q <= 1'b0;
            total_q  <= '0;
            found_q  <= '0;
            miss_q   <= '0;
            drop_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            total_q  <= total_d;
            found_q  <= found_d;
            miss_q   <= miss_d;
            drop_q   <= drop_d;
        end
    end

    assign total_cnt_o = total_q;
    assign found_cnt_o = found_q;
    assign miss_cnt_o  = miss_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_ht_res_collector.sv
// Directed plus random checks of ht_res_collector against a queue-based reference model.
module tb_ht_res_collector;
    import hash_table::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, in_vld = 1'b0, rd_req = 1'b0, clr = 1'b0;
    bit            sel = 1'b0;
    ht_res_entry_t in_e = '0;

    ht_res_if if_a ();
    ht_res_if if_b ();

    assign if_a.valid   = in_vld & ~sel;
    assign if_a.cmd     = in_e.cmd;
    assign if_a.key     = in_e.key;
    assign if_a.value   = in_e.value;
    assign if_a.rescode = in_e.rescode;
    assign if_b.valid   = in_vld & sel;
    assign if_b.cmd     = in_e.cmd;
    assign if_b.key     = in_e.key;
    assign if_b.value   = in_e.value;
    assign if_b.rescode = in_e.rescode;

    logic a_rvld, b_rvld;
    ht_cmd_t a_cmd, b_cmd;
    logic [31:0] a_key, b_key;
    logic [15:0] a_val, b_val;
    ht_rescode_t a_rc, b_rc;
    logic [31:0] a_tot, a_fnd, a_mis, a_drp;
    logic [3:0]  b_tot, b_fnd, b_mis, b_drp;

    ht_res_collector #(.FIFO_DEPTH(8), .CNT_WIDTH(32), .DROP_ON_FULL(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .ht_res_in(if_a), .clear_i(clr & ~sel), .rd_req_i(rd_req & ~sel),
        .rd_valid_o(a_rvld), .rd_cmd_o(a_cmd), .rd_key_o(a_key), .rd_value_o(a_val),
        .rd_rescode_o(a_rc), .total_cnt_o(a_tot), .found_cnt_o(a_fnd), .miss_cnt_o(a_mis),
        .drop_cnt_o(a_drp));

    ht_res_collector #(.FIFO_DEPTH(8), .CNT_WIDTH(4), .DROP_ON_FULL(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .ht_res_in(if_b), .clear_i(clr & sel), .rd_req_i(rd_req & sel),
        .rd_valid_o(b_rvld), .rd_cmd_o(b_cmd), .rd_key_o(b_key), .rd_value_o(b_val),
        .rd_rescode_o(b_rc), .total_cnt_o(b_tot), .found_cnt_o(b_fnd), .miss_cnt_o(b_mis),
        .drop_cnt_o(b_drp));

    // Observed outputs of whichever instance is under test.
    logic          o_rdy, o_rvld;
    ht_res_entry_t o_ent;
    logic [31:0]   o_tot, o_fnd, o_mis, o_drp;
    always_comb begin
        if (sel) begin
            o_rdy = if_b.ready; o_rvld = b_rvld; o_ent = '{b_cmd, b_key, b_val, b_rc};
            o_tot = 32'(b_tot); o_fnd = 32'(b_fnd); o_mis = 32'(b_mis); o_drp = 32'(b_drp);
        end else begin
            o_rdy = if_a.ready; o_rvld = a_rvld; o_ent = '{a_cmd, a_key, a_val, a_rc};
            o_tot = a_tot; o_fnd = a_fnd; o_mis = a_mis; o_drp = a_drp;
        end
    end

    // Reference model: a bounded queue plus saturating integer counters.
    ht_res_entry_t mq[$];
    ht_res_entry_t dut_pops[$];
    logic [31:0]   m_tot, m_fnd, m_mis, m_drp;
    logic [31:0]   cmax = 32'hFFFF_FFFF;
    bit            m_rdyen = 1'b0;
    int            n_chk = 0, n_pass = 0, n_acc = 0;

    function automatic bit m_rdy();
        return m_rdyen && (sel || mq.size() < 8);
    endfunction

    function automatic logic [31:0] sinc(input logic [31:0] x);
        return (x == cmax) ? x : x + 32'd1;
    endfunction

    function automatic ht_res_entry_t mk(input ht_cmd_t c, input logic [31:0] k,
                                         input logic [15:0] v, input ht_rescode_t r);
        ht_res_entry_t e;
        e.cmd = c; e.key = k; e.value = v; e.rescode = r;
        return e;
    endfunction

    function automatic ht_res_entry_t rand_entry();
        int r;
        ht_rescode_t rc;
        r = $urandom_range(0, 9);
        if (r < 4)      rc = SEARCH_FOUND;
        else if (r < 7) rc = SEARCH_NOT_SUCCESS_NO_ENTRY;
        else            rc = ht_rescode_t'(3'($urandom_range(0, 5)));
        return mk(ht_cmd_t'(2'($urandom_range(0, 3))), $urandom, 16'($urandom), rc);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit acc, full, pop;
        full = (mq.size() >= 8);
        acc  = in_vld && m_rdy();
        pop  = rd_req && (mq.size() != 0);
        if (rd_req && o_rvld) dut_pops.push_back(o_ent);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_tot = 0; m_fnd = 0; m_mis = 0; m_drp = 0;
            m_rdyen = 1'b0;
        end else begin
            m_rdyen = 1'b1;
            if (pop) void'(mq.pop_front());
            if (acc) n_acc++;
            if (acc && !full) mq.push_back(in_e);
            if (clr) begin
                m_tot = 0; m_fnd = 0; m_mis = 0; m_drp = 0;
            end else if (acc) begin
                m_tot = sinc(m_tot);
                if (in_e.rescode == SEARCH_FOUND) m_fnd = sinc(m_fnd);
                if (in_e.rescode == SEARCH_NOT_SUCCESS_NO_ENTRY) m_mis = sinc(m_mis);
                if (full) m_drp = sinc(m_drp);
            end
        end
        #1;
    endtask

    task automatic check_all(input string t);
        chk({t, ":ready"}, 64'(o_rdy), 64'(m_rdy()));
        chk({t, ":rd_valid"}, 64'(o_rvld), 64'(mq.size() != 0));
        if (mq.size() != 0) chk({t, ":head"}, 64'(o_ent), 64'(mq[0]));
        chk({t, ":total"}, 64'(o_tot), 64'(m_tot));
        chk({t, ":found"}, 64'(o_fnd), 64'(m_fnd));
        chk({t, ":miss"}, 64'(o_mis), 64'(m_mis));
        chk({t, ":drop"}, 64'(o_drp), 64'(m_drp));
    endtask

    task automatic cyc(input string t, input bit v, input ht_res_entry_t e,
                       input bit rq, input bit c);
        in_vld = v; in_e = e; rd_req = rq; clr = c;
        tick();
        check_all(t);
    endtask

    task automatic do_reset(input bit s);
        sel = s;
        cmax = s ? 32'd15 : 32'hFFFF_FFFF;
        in_vld = 1'b0; rd_req = 1'b0; clr = 1'b0; rst = 1'b1;
        tick(); tick();
        check_all("reset");
        chk("reset_ready_low", 64'(o_rdy), 64'd0);
        rst = 1'b0;
        tick();
        check_all("post_reset");
        chk("ready_after_release", 64'(o_rdy), 64'd1);
    endtask

    task automatic drain(input string t);
        dut_pops.delete();
        for (int i = 0; i < 20 && (o_rvld || mq.size() != 0); i++) cyc(t, 1'b0, in_e, 1'b1, 1'b0);
        chk({t, ":emptied"}, 64'(o_rvld), 64'd0);
    endtask

    initial begin
        ht_res_entry_t e0, e1, e2;

        // Backpressure instance: basic in-order flow with immediate reads.
        do_reset(1'b0);
        e0 = mk(SEARCH, 32'h0100_0000, 16'h1234, SEARCH_FOUND);
        e1 = mk(SEARCH, 32'h0200_0000, 16'hABCD, SEARCH_FOUND);
        e2 = mk(SEARCH, 32'h1122_3344, 16'h0000, SEARCH_NOT_SUCCESS_NO_ENTRY);
        cyc("flow0", 1'b1, e0, 1'b1, 1'b0);
        chk("flow_head0", 64'(o_ent), 64'(e0));
        cyc("flow1", 1'b1, e1, 1'b1, 1'b0);
        chk("flow_head1", 64'(o_ent), 64'(e1));
        cyc("flow2", 1'b1, e2, 1'b1, 1'b0);
        chk("flow_head2", 64'(o_ent), 64'(e2));
        cyc("flow3", 1'b0, e2, 1'b1, 1'b0);
        chk("flow_empty", 64'(o_rvld), 64'd0);
        chk("flow_total", 64'(o_tot), 64'd3);
        chk("flow_found", 64'(o_fnd), 64'd2);
        chk("flow_miss", 64'(o_mis), 64'd1);

        // Ten held valids into an 8-deep buffer, then reads start.
        do_reset(1'b0);
        n_acc = 0;
        dut_pops.delete();
        for (int t = 0; t < 10; t++)
            cyc("bp_fill", 1'b1, mk(SEARCH, 32'(100 + n_acc), 16'(3 * n_acc), SEARCH_FOUND), 1'b0, 1'b0);
        chk("bp_ready_low_when_full", 64'(o_rdy), 64'd0);
        chk("bp_total_at_full", 64'(o_tot), 64'd8);
        for (int t = 0; t < 40 && (n_acc < 10 || mq.size() != 0); t++)
            cyc("bp_drain", n_acc < 10, mk(SEARCH, 32'(100 + n_acc), 16'(3 * n_acc), SEARCH_FOUND), 1'b1, 1'b0);
        chk("bp_pop_count", 64'(dut_pops.size()), 64'd10);
        for (int i = 0; i < 10 && i < dut_pops.size(); i++)
            chk("bp_pop_order", 64'(dut_pops[i]), 64'(mk(SEARCH, 32'(100 + i), 16'(3 * i), SEARCH_FOUND)));

        // Mid-stream reset with 5 entries buffered and an accept in flight.
        for (int i = 0; i < 5; i++) cyc("rst_fill", 1'b1, rand_entry(), 1'b0, 1'b0);
        in_vld = 1'b1; in_e = rand_entry(); rst = 1'b1;
        tick();
        check_all("mid_reset");
        chk("mid_reset_rvld", 64'(o_rvld), 64'd0);
        chk("mid_reset_total", 64'(o_tot), 64'd0);
        rst = 1'b0; in_vld = 1'b0;
        tick();
        check_all("mid_release");
        chk("mid_release_ready", 64'(o_rdy), 64'd1);

        for (int t = 0; t < 300; t++)
            cyc("rand_bp", $urandom_range(0, 3) != 0, rand_entry(), $urandom_range(0, 2) == 0,
                $urandom_range(0, 40) == 0);

        // Drop-on-full instance with 4-bit counters.
        do_reset(1'b1);
        for (int i = 0; i < 10; i++)
            cyc("drop_fill", 1'b1, mk(SEARCH, 32'(200 + i), 16'(i), SEARCH_FOUND), 1'b0, 1'b0);
        chk("drop_count", 64'(o_drp), 64'd2);
        chk("drop_total", 64'(o_tot), 64'd10);
        drain("drop_drain");
        chk("drop_kept", 64'(dut_pops.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_pops.size(); i++)
            chk("drop_kept_order", 64'(dut_pops[i]), 64'(mk(SEARCH, 32'(200 + i), 16'(i), SEARCH_FOUND)));

        for (int i = 0; i < 8; i++) cyc("full_fill", 1'b1, mk(INSERT, 32'(300 + i), 16'(i), INSERT_SUCCESS), 1'b0, 1'b0);
        cyc("full_pushpop", 1'b1, mk(INSERT, 32'd399, 16'd0, INSERT_SUCCESS), 1'b1, 1'b0);
        drain("full_drain");
        chk("full_pushpop_occ", 64'(dut_pops.size()), 64'd7);
        if (dut_pops.size() == 7) chk("full_pushpop_last", 64'(dut_pops[6].key), 64'd307);

        for (int i = 0; i < 4; i++) cyc("half_fill", 1'b1, mk(DELETE, 32'(400 + i), 16'(i), DELETE_SUCCESS), 1'b0, 1'b0);
        cyc("half_pushpop", 1'b1, mk(DELETE, 32'd404, 16'd4, DELETE_SUCCESS), 1'b1, 1'b0);
        drain("half_drain");
        chk("half_pushpop_occ", 64'(dut_pops.size()), 64'd4);
        if (dut_pops.size() == 4) chk("half_pushpop_last", 64'(dut_pops[3].key), 64'd404);

        // Saturation and clear priority.
        do_reset(1'b1);
        for (int i = 0; i < 15; i++)
            cyc("sat_fill", 1'b1, mk(SEARCH, 32'(i), 16'(i), SEARCH_FOUND), 1'b1, 1'b0);
        chk("sat_at_max", 64'(o_tot), 64'd15);
        cyc("sat_more", 1'b1, mk(SEARCH, 32'd99, 16'd9, SEARCH_FOUND), 1'b1, 1'b0);
        chk("sat_total_hold", 64'(o_tot), 64'd15);
        chk("sat_found_hold", 64'(o_fnd), 64'd15);
        cyc("clr_with_accept", 1'b1, mk(SEARCH, 32'd98, 16'd8, SEARCH_FOUND), 1'b1, 1'b1);
        chk("clr_total", 64'(o_tot), 64'd0);
        chk("clr_found", 64'(o_fnd), 64'd0);
        cyc("post_clr", 1'b1, mk(SEARCH, 32'd97, 16'd7, SEARCH_NOT_SUCCESS_NO_ENTRY), 1'b1, 1'b0);
        chk("post_clr_total", 64'(o_tot), 64'd1);

        for (int t = 0; t < 300; t++)
            cyc("rand_drop", $urandom_range(0, 3) != 0, rand_entry(), $urandom_range(0, 2) == 0,
                $urandom_range(0, 40) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
